oled_digit_formatter: RTL and testbench
=======================================

# oled_digit_formatter

Upstream feeder for the OLED manager's pixel-block RAM. It accepts a binary value (speed, distance, cadence) and converts it to decimal digits with a sequential double-dabble. It applies leading-zero blanking and saturation, then emits one block-write per changed digit over a valid/ready port. That port is bridged into the manager's block slots, where each 5-bit word selects a resource picture: digits 0–9 and a blank glyph.

## Interface
- VALUE_WIDTH, 14: width of input binary value.
- DIGITS, 4: number of decimal digits (OLED blocks) driven; 1..6.
- BASE_BLOCK, 0: block index of most significant digit; digit k (k=0 MSD) goes to BASE_BLOCK+k; BASE_BLOCK+DIGITS-1 ≤ 31.
- BLANK_CODE, 10: resource index written for a blanked digit.
- BLANK_EN, 1: 1 enables leading-zero blanking.
- HCLK  in  1  clock, rising edge.
- HRESET  in  1  reset; one clock; reset is asynchronous and active-high.
- value_valid  in  1  new value offered.
- value  in  VALUE_WIDTH  unsigned binary value.
- value_ready  out  1  high only in IDLE; transfer on value_valid && value_ready.
- blk_valid  out  1  block-write request.
- blk_addr  out  5  target block index.
- blk_data  out  5  resource index (0..9 or BLANK_CODE).
- blk_ready  in  1  sink accepts; transfer on blk_valid && blk_ready.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, CONVERT, EMIT.
- IDLE:
  - value_ready=1.
  - On transfer, capture min(value, 10^DIGITS−1) into a shift register and clear the BCD register (4·DIGITS bits).
  - Clear the conversion counter; go to CONVERT.
- CONVERT: one shift per cycle for VALUE_WIDTH cycles.
  - Each cycle, every BCD nibble ≥5 gets +3.
  - Then {bcd, shift} shifts left by 1.
  - Counter width is clog2(VALUE_WIDTH+1).
  - After the VALUE_WIDTH-th shift, clear digit index k; go to EMIT.
- EMIT: evaluate digit k per step.
  - Display code = BLANK_CODE if BLANK_EN and k<DIGITS−1 and nibbles 0..k are all zero; else the nibble. The LSD is never blanked.
  - If code ≠ shadow[k]: blk_valid=1, blk_addr=BASE_BLOCK+k, blk_data=code. Hold until the handshake; on transfer, shadow[k]←code and k←k+1.
  - If code = shadow[k]: no request; k←k+1 next cycle.
  - After handling k=DIGITS−1, go to IDLE.
- Shadow registers hold the last code written per block. After reset they hold 5'h1F (matches no valid code), so the first value writes all DIGITS blocks.
- blk_addr/blk_data/blk_valid decode from registers only; no combinational path from any input.
- value_valid outside IDLE is ignored (value_ready=0); upstream must hold it.
- blk_ready outside a request is ignored.

## Timing
- Reset values:
  - value_ready=1, busy=0, blk_valid=0, blk_addr=0, blk_data=0.
  - State IDLE; shadows all 5'h1F; BCD, counters and k all 0.
- Acceptance at edge T:
  - CONVERT occupies edges T+1..T+VALUE_WIDTH.
  - First blk_valid can be high in the cycle after edge T+VALUE_WIDTH (VALUE_WIDTH+1 cycles after acceptance).
- EMIT costs 1 cycle per skipped digit, and ≥1 cycle per written digit (1 with blk_ready held high).
- Best-case total, all digits changed and blk_ready=1: VALUE_WIDTH+DIGITS cycles from acceptance until value_ready returns high.
- Back-pressure: while blk_valid=1 and blk_ready=0, blk_addr and blk_data are stable and blk_valid does not drop.
- Reset mid-operation, any state: outputs return to reset values asynchronously and the pending request is abandoned. Shadows are reset, so the next value rewrites every block.
- Same value re-sent: completes in VALUE_WIDTH+DIGITS cycles with zero writes.

## Test plan
- **First value after reset.** Reset, then value=42 (defaults). Required: writes (0,10),(1,10),(2,4),(3,2) in order; value_ready high again 18 cycles after acceptance with blk_ready tied high.
- **Single-digit change.** Then value=47. Required: exactly one write, (3,7).
- **Zero.** Then value=0. Required: writes (2,10),(3,0) only; block 3 shows 0, not blank.
- **Saturation.** value=12000. Required: clamped to 9999; writes (0,9),(1,9),(2,9),(3,9).
- **Back-pressure.** value=5000 with blk_ready low 5 cycles during first request. Required: blk_valid high and (0,5) stable across all 5 cycles; value_valid pulsed mid-EMIT is ignored; busy=1 throughout.
- **Reset mid-EMIT.** Assert HRESET during the second write of a 4-write update. Required: blk_valid=0 immediately; after release, value=42 produces all 4 writes again.

Source files
------------

// File: rtl/oled_digit_formatter_if.sv
// Purpose: value-in / block-write-out handshake bundle for the OLED digit formatter.
// Latency: n/a (wiring only).
// Backpressure: value side via value_valid/value_ready, block side via blk_valid/blk_ready.
interface oled_digit_formatter_if #(
    parameter int VALUE_WIDTH = 14
);
    logic                   value_valid;
    logic [VALUE_WIDTH-1:0] value;
    logic                   value_ready;
    logic                   blk_valid;
    logic [4:0]             blk_addr;
    logic [4:0]             blk_data;
    logic                   blk_ready;
    logic                   busy;

    // Upstream / sink side (drives values in, accepts block writes)
    modport master (
        output value_valid, value, blk_ready,
        input  value_ready, blk_valid, blk_addr, blk_data, busy
    );

    // Formatter side
    modport slave (
        input  value_valid, value, blk_ready,
        output value_ready, blk_valid, blk_addr, blk_data, busy
    );
endinterface

// File: rtl/oled_digit_formatter.sv
// Purpose: binary value -> clamped decimal digits (serial double-dabble), leading-zero blanking, one block write per changed digit.
// Latency: VALUE_WIDTH cycles of conversion, then 1 cycle per digit (more while the sink stalls); VALUE_WIDTH+DIGITS best case.
// Backpressure: value_ready only in IDLE; a pending block write holds addr/data/valid stable until blk_ready.
module oled_digit_formatter #(
    parameter int         VALUE_WIDTH = 14,
    parameter int         DIGITS      = 4,
    parameter int         BASE_BLOCK  = 0,
    parameter logic [4:0] BLANK_CODE  = 5'd10,
    parameter bit         BLANK_EN    = 1'b1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    oled_digit_formatter_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + VALUE_WIDTH;
    localparam int CNT_W = $clog2(VALUE_WIDTH + 1);
    localparam int K_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Largest value representable in DIGITS decimal digits; larger inputs saturate here.
    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

    // One double-dabble step on the concatenated {bcd, binary} register:
    // correct every nibble >= 5 by +3, then shift the whole thing left by one.
    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int j = 0; j < DIGITS; j++) begin
            if (t[VALUE_WIDTH + 4*j +: 4] >= 4'd5) begin
                t[VALUE_WIDTH + 4*j +: 4] = t[VALUE_WIDTH + 4*j +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    // Display code of digit idx (0 = most significant). A digit is blanked
    // when it and everything above it is zero; the last digit always shows.
    function automatic logic [4:0] code_of(input logic [BCD_W-1:0] bcd, input int idx);
        logic       lead_zero;
        logic [3:0] nib;
        lead_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (j <= idx && bcd[4*(DIGITS-1-j) +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
        nib = bcd[4*(DIGITS-1-idx) +: 4];
        if (BLANK_EN && (idx < DIGITS - 1) && lead_zero) begin
            return BLANK_CODE;
        end
        return {1'b0, nib};
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_EMIT
    } state_t;

    state_t                 state_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [VALUE_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [K_W-1:0]         k_q;
    logic [4:0]             shadow_q [DIGITS];
    logic                   value_ready_q;
    logic                   busy_q;
    logic                   blk_valid_q;
    logic [4:0]             blk_addr_q;
    logic [4:0]             blk_data_q;

    logic [BCD_W-1:0]       bcd_d;
    logic [VALUE_WIDTH-1:0] shift_d;
    logic [CNT_W-1:0]       cnt_d;
    logic [K_W-1:0]         k_d;
    logic                   last_k;
    logic [4:0]             code_first;
    logic [4:0]             code_next;
    logic [63:0]            value_ext;
    logic [VALUE_WIDTH-1:0] value_clamped;

    // Next-state helpers: conversion step, digit index advance and look-ahead
    // display codes, so the block-write outputs can be loaded as registers.
    always_comb begin
        {bcd_d, shift_d} = dd_step({bcd_q, shift_q});
        cnt_d            = cnt_q + 1'b1;
        last_k           = (k_q == K_W'(DIGITS - 1));
        k_d              = last_k ? k_q : k_q + 1'b1;
        // Digit 0 of the value that the final conversion step produces.
        code_first       = code_of(bcd_d, 0);
        // Digit k+1 of the finished conversion (k_d saturates at the last digit).
        code_next        = code_of(bcd_q, int'(k_d));
        value_ext        = 64'(bus.value);
        value_clamped    = (value_ext > MAX_VAL) ? VALUE_WIDTH'(MAX_VAL) : bus.value;
    end

    // Control FSM: accept, convert, then walk the digits issuing writes for changed ones.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q       <= S_IDLE;
            bcd_q         <= '0;
            shift_q       <= '0;
            cnt_q         <= '0;
            k_q           <= '0;
            value_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            blk_valid_q   <= 1'b0;
            blk_addr_q    <= '0;
            blk_data_q    <= '0;
            // 5'h1F matches no displayable code, so the first value rewrites every block.
            for (int i = 0; i < DIGITS; i++) begin
                shadow_q[i] <= 5'h1F;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.value_valid) begin
                        shift_q       <= value_clamped;
                        bcd_q         <= '0;
                        cnt_q         <= '0;
                        value_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    bcd_q   <= bcd_d;
                    shift_q <= shift_d;
                    cnt_q   <= cnt_d;
                    if (cnt_q == CNT_W'(VALUE_WIDTH - 1)) begin
                        k_q         <= '0;
                        state_q     <= S_EMIT;
                        blk_valid_q <= (code_first != shadow_q[0]);
                        blk_addr_q  <= 5'(BASE_BLOCK);
                        blk_data_q  <= code_first;
                    end
                end
                S_EMIT: begin
                    // Advance when nothing is pending or the pending write completes.
                    if (!blk_valid_q || bus.blk_ready) begin
                        if (blk_valid_q) begin
                            shadow_q[k_q] <= blk_data_q;
                        end
                        if (last_k) begin
                            blk_valid_q   <= 1'b0;
                            value_ready_q <= 1'b1;
                            busy_q        <= 1'b0;
                            state_q       <= S_IDLE;
                        end else begin
                            k_q         <= k_d;
                            blk_valid_q <= (code_next != shadow_q[k_d]);
                            blk_addr_q  <= 5'(BASE_BLOCK) + 5'(k_d);
                            blk_data_q  <= code_next;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.value_ready = value_ready_q;
    assign bus.busy        = busy_q;
    assign bus.blk_valid   = blk_valid_q;
    assign bus.blk_addr    = blk_addr_q;
    assign bus.blk_data    = blk_data_q;
endmodule

// File: tb/tb_oled_digit_formatter.sv
// Purpose: self-checking bench for oled_digit_formatter (directed plan + randomized values, scoreboarded writes).
// Latency: checks VALUE_WIDTH+DIGITS cycles per transaction when blk_ready is held high.
// Backpressure: exercises stalled block writes, ignored value_valid while busy, and reset mid-write.
module tb_oled_digit_formatter;
    localparam int VW    = 14;
    localparam int ND    = 4;
    localparam int BASE  = 0;
    localparam int BLANK = 10;
    localparam int MAXV  = 10**ND - 1;

    logic clk;
    logic rst;

    oled_digit_formatter_if #(.VALUE_WIDTH(VW)) bus ();

    oled_digit_formatter #(
        .VALUE_WIDTH(VW),
        .DIGITS     (ND),
        .BASE_BLOCK (BASE),
        .BLANK_CODE (5'(BLANK)),
        .BLANK_EN   (1'b1)
    ) dut (
        .HCLK  (clk),
        .HRESET(rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [9:0] exp_q[$];
    int         shadow[ND];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, blanking when the value is below
    // the digit's place value; queue a write for every code that differs.
    function automatic void model_push(input int v);
        int vc;
        int p;
        int code;
        vc = (v > MAXV) ? MAXV : v;
        for (int k = 0; k < ND; k++) begin
            p = 10**(ND - 1 - k);
            if (k < ND - 1 && vc < p) code = BLANK;
            else                      code = (vc / p) % 10;
            if (code != shadow[k]) begin
                exp_q.push_back({5'(BASE + k), 5'(code)});
                shadow[k] = code;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < ND; k++) shadow[k] = 31;
        exp_q.delete();
    endfunction

    // Monitor: every completed block write is popped and compared.
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst && bus.blk_valid && bus.blk_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                         bus.blk_addr, bus.blk_data);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", bus.blk_addr, e[9:5]);
                check("write_data", bus.blk_data, e[4:0]);
            end
        end
    end

    // Handshake one value in; returns #1 after the accepting edge.
    task automatic accept(input int v);
        model_push(v);
        @(posedge clk); #1;
        check("ready_before_send", bus.value_ready, 1);
        bus.value_valid = 1'b1;
        bus.value       = VW'(v);
        @(posedge clk); #1;
        bus.value_valid = 1'b0;
        check("busy_after_accept", bus.busy, 1);
    endtask

    task automatic wait_idle(input bit rand_rdy, output int n);
        n = 0;
        while (!bus.value_ready && n < 300) begin
            if (rand_rdy) bus.blk_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        bus.blk_ready = 1'b1;
        if (!bus.value_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", n);
        end
    endtask

    task automatic send_value(input int v, input bit rand_rdy, input bit chk_lat);
        int n;
        accept(v);
        wait_idle(rand_rdy, n);
        if (chk_lat) check("latency", n, VW + ND);
        check("writes_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int v;
        rst             = 1'b1;
        bus.value_valid = 1'b0;
        bus.value       = '0;
        bus.blk_ready   = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_value_ready", bus.value_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_blk_valid", bus.blk_valid, 0);
        check("rst_blk_addr", bus.blk_addr, 0);
        check("rst_blk_data", bus.blk_data, 0);

        // Directed plan: first value, one-digit change, zero, same value, saturation.
        send_value(42, 1'b0, 1'b1);
        send_value(47, 1'b0, 1'b1);
        send_value(0, 1'b0, 1'b1);
        send_value(0, 1'b0, 1'b1);
        send_value(12000, 1'b0, 1'b1);

        // Back-pressure on the first write of 5000, with a stray value_valid mid-EMIT.
        bus.blk_ready = 1'b0;
        accept(5000);
        repeat (VW) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", bus.blk_valid, 1);
            check("bp_addr", bus.blk_addr, BASE);
            check("bp_data", bus.blk_data, 5);
            check("bp_busy", bus.busy, 1);
            check("bp_value_ready", bus.value_ready, 0);
            if (i == 2) begin
                bus.value_valid = 1'b1;
                bus.value       = VW'(123);
            end else begin
                bus.value_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.value_valid = 1'b0;
        bus.blk_ready   = 1'b1;
        wait_idle(1'b0, n);
        check("bp_writes_outstanding", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        check("bp_no_stray_accept", bus.busy, 0);

        // Reset while the second of four writes is stalled.
        accept(42);
        repeat (VW) @(posedge clk);
        #1;
        check("mr_first_valid", bus.blk_valid, 1);
        check("mr_first_data", bus.blk_data, BLANK);
        @(posedge clk); #1;
        bus.blk_ready = 1'b0;
        check("mr_second_valid", bus.blk_valid, 1);
        check("mr_second_addr", bus.blk_addr, BASE + 1);
        check("mr_second_data", bus.blk_data, BLANK);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mr_blk_valid", bus.blk_valid, 0);
        check("mr_value_ready", bus.value_ready, 1);
        check("mr_busy", bus.busy, 0);
        model_reset();
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.blk_ready = 1'b1;
        send_value(42, 1'b0, 1'b1);

        // Randomized values and random sink stalls.
        for (int t = 0; t < 24; t++) begin
            case (t % 4)
                0:       v = int'($urandom_range(0, 9));
                1:       v = int'($urandom_range(0, 999));
                2:       v = int'($urandom_range(0, 16383));
                default: v = int'($urandom_range(9990, 16383));
            endcase
            send_value(v, 1'b1, 1'b0);
        end
        // Resend with the sink always ready: no writes, best-case latency.
        send_value(v, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
